// File: rtl/overflow_burst_accum.sv
// Burst accumulator behind the signed adder stage: sums LEN samples with signed
// saturation, counts overflows and hands one result downstream via valid/ready.
// Optional feature macro: OVF_BURST_REPAIR_EN (clamp overflowed samples before adding).
module overflow_burst_accum #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     s,
  input  logic                 overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     acc,
  output logic                 sat,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and results stay frozen while valid waits.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state, state_n;
  logic [CNT_W-1:0]     remaining;
  logic                 accept;
  logic [WIDTH-1:0]     eff_s;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH-1:0]     sum_sat;
  logic                 clamp;

  assign accept = in_valid && in_ready;

`ifdef OVF_BURST_REPAIR_EN
  // A set MSB on an overflowed sum means the true result was positive.
  always_comb begin
    eff_s = s;
    if (overflow) eff_s = s[WIDTH-1] ? POS_MAX : NEG_MIN;
  end
`else
  assign eff_s = s;
`endif

  always_comb begin
    sum_ext = {acc[WIDTH-1], acc} + {eff_s[WIDTH-1], eff_s};
    sum_sat = sum_ext[WIDTH-1:0];
    clamp   = 1'b0;
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      clamp   = 1'b1;
      sum_sat = sum_ext[WIDTH] ? NEG_MIN : POS_MAX;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && remaining == CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      ovf_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        remaining <= len;
        acc       <= '0;
        sat       <= 1'b0;
        ovf_count <= '0;
      end else if (accept) begin
        acc       <= sum_sat;
        sat       <= sat | clamp;
        remaining <= remaining - CNT_W'(1);
        if (overflow && ovf_count != {OVF_CNT_W{1'b1}})
          ovf_count <= ovf_count + OVF_CNT_W'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule
